// File: rtl/asym_width_fifo.sv
// asym_width_fifo: byte-in, RATIO-byte-out single-clock FIFO on one RAM with flush and registered reads.
// Define ASYM_FIFO_ERROR_FLAGS_EN to add sticky overflow_o/underflow_o ports.
module asym_width_fifo #(
  parameter int NARROW_WIDTH = 8,
  parameter int RATIO = 2,
  parameter int WIDE_DEPTH = 256
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            wr_en_i,
  input  logic [NARROW_WIDTH-1:0]         wr_data_i,
  output logic                            full_o,
  input  logic                            rd_en_i,
  output logic [NARROW_WIDTH*RATIO-1:0]   rd_data_o,
  output logic                            rd_valid_o,
  output logic [$clog2(WIDE_DEPTH):0]     words_avail_o
`ifdef ASYM_FIFO_ERROR_FLAGS_EN
  ,
  output logic                            overflow_o,
  output logic                            underflow_o
`endif
);
  localparam int LW = $clog2(RATIO);
  localparam int RW = $clog2(WIDE_DEPTH);
  localparam int WW = RW + LW;
  localparam logic [WW:0] CAP = WW'(1) << WW;
  localparam logic [WW:0] W_ONE = 1;
  localparam logic [RW:0] R_ONE = 1;
  logic [RATIO-1:0][NARROW_WIDTH-1:0] mem [WIDE_DEPTH];
  logic [WW:0] wptr_q, wptr_d, count;
  logic [RW:0] rptr_q, rptr_d;
  logic [NARROW_WIDTH*RATIO-1:0] rd_data_q;
  logic rd_valid_q, wr_ok, rd_ok, clr;
  // the read pointer scaled to narrow units makes the pointer difference the byte occupancy
  assign count = wptr_q - {rptr_q, {LW{1'b0}}};
  assign words_avail_o = count[WW:LW];
  assign full_o = count == CAP;
  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && words_avail_o != '0;
  assign clr = rst_i || flush_i;
  always_comb begin
    wptr_d = clr ? '0 : wr_ok ? wptr_q + W_ONE : wptr_q;
    rptr_d = clr ? '0 : rd_ok ? rptr_q + R_ONE : rptr_q;
  end
  always_ff @(posedge clk_i) begin
    wptr_q <= wptr_d;
    rptr_q <= rptr_d;
    rd_valid_q <= !clr && rd_ok;
    if (rst_i) rd_data_q <= '0;
    else if (!flush_i && rd_ok) rd_data_q <= mem[rptr_q[RW-1:0]];
  end
  // a write never targets the word being read: at full the write is dropped
  always_ff @(posedge clk_i)
    if (!clr && wr_ok) mem[wptr_q[WW-1:LW]][wptr_q[LW-1:0]] <= wr_data_i;
  assign rd_data_o = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`ifdef ASYM_FIFO_ERROR_FLAGS_EN
  logic ovf_q, udf_q;
  always_ff @(posedge clk_i) begin
    ovf_q <= clr ? 1'b0 : ovf_q || (wr_en_i && full_o);
    udf_q <= clr ? 1'b0 : udf_q || (rd_en_i && words_avail_o == '0);
  end
  assign overflow_o = ovf_q;
  assign underflow_o = udf_q;
`endif
endmodule
